// File: rtl/mesi_arb_pkg.sv
// rtl/mesi_arb_pkg.sv - command/state types and constants shared by the MESI main-bus arbiter
package mesi_arb_pkg;

    localparam int CPU_NUM = 4;

    typedef enum logic [2:0] {
        MBUS_NOP   = 3'd0,
        MBUS_WR    = 3'd1,
        MBUS_RD    = 3'd2,
        MBUS_BR_WR = 3'd3,
        MBUS_BR_RD = 3'd4
    } mbus_cmd_t;

    typedef enum logic [2:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2
    } cbus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEM,
        ST_DONE
    } arb_state_t;

    // Encodings outside the defined set behave exactly like NOP.
    function automatic logic mbus_is_active(input logic [2:0] cmd);
        return (cmd == MBUS_WR) || (cmd == MBUS_RD) ||
               (cmd == MBUS_BR_WR) || (cmd == MBUS_BR_RD);
    endfunction

endpackage

// File: rtl/mesi_rr_pick.sv
// rtl/mesi_rr_pick.sv - combinational round-robin picker over four requesters
module mesi_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] id
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;

    // req_rot[i] is requester (ptr + i) mod 4, so the lowest set bit is the winner.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 4];

    always_comb begin
        valid  = |req;
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 2'(i);
            end
        end
        id = ptr + offset;
    end

endmodule

// File: rtl/mesi_mbus_arb.sv
// rtl/mesi_mbus_arb.sv - MESI main-bus arbiter and sequencer; MESI_ARB_SNOOP_TIMEOUT_EN enables the snoop timeout
module mesi_mbus_arb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int CPU_NUM        = 4,
    parameter int SNOOP_TIMEOUT  = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CPU_NUM*MBUS_CMD_WIDTH-1:0]  mbus_cmd_i,
    input  logic [CPU_NUM*ADDR_WIDTH-1:0]      mbus_addr_i,
    output logic [CPU_NUM-1:0]                 mbus_ack_o,
    output logic [CPU_NUM*CBUS_CMD_WIDTH-1:0]  cbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]              cbus_addr_o,
    input  logic [CPU_NUM-1:0]                 cbus_ack_i,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    input  logic                               mem_ack_i,
    output logic [1:0]                         grant_id_o,
    output logic                               busy_o,
    output logic                               snoop_err_o
);

    import mesi_arb_pkg::*;

    arb_state_t                state;
    logic [CPU_NUM-1:0]        req;
    logic [CPU_NUM-1:0]        mask;
    logic [CPU_NUM-1:0]        ack_seen;
    logic [CPU_NUM-1:0]        others;
    logic [CPU_NUM-1:0]        seen_next;
    logic [1:0]                rr_ptr;
    logic [1:0]                gid;
    logic [1:0]                pick_id;
    logic                      pick_valid;
    logic [MBUS_CMD_WIDTH-1:0] cmd_arr  [CPU_NUM];
    logic [ADDR_WIDTH-1:0]     addr_arr [CPU_NUM];
    logic [CBUS_CMD_WIDTH-1:0] cbus_q   [CPU_NUM];
    logic [MBUS_CMD_WIDTH-1:0] sel_cmd;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [CBUS_CMD_WIDTH-1:0] snoop_cmd;

`ifdef MESI_ARB_SNOOP_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        snoop_err_q;

    assign snoop_err_o = snoop_err_q;
`else
    assign snoop_err_o = 1'b0;
`endif

    for (genvar k = 0; k < CPU_NUM; k++) begin : g_cpu
        assign cmd_arr[k]  = mbus_cmd_i[k*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
        assign addr_arr[k] = mbus_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign req[k]      = mbus_is_active(cmd_arr[k]) && !mask[k];
        assign cbus_cmd_o[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = cbus_q[k];
    end

    mesi_rr_pick u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    assign sel_cmd   = cmd_arr[pick_id];
    assign sel_addr  = addr_arr[pick_id];
    assign snoop_cmd = (sel_cmd == MBUS_BR_WR) ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;

    // Acks from the requester itself are masked out here, so they never count.
    assign others    = ~(CPU_NUM'(1) << gid);
    assign seen_next = ack_seen | (cbus_ack_i & others);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            mask        <= '0;
            ack_seen    <= '0;
            gid         <= '0;
            grant_id_o  <= '0;
            busy_o      <= 1'b0;
            mbus_ack_o  <= '0;
            cbus_addr_o <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            for (int k = 0; k < CPU_NUM; k++) begin
                cbus_q[k] <= '0;
            end
`ifdef MESI_ARB_SNOOP_TIMEOUT_EN
            tmo_cnt     <= '0;
            snoop_err_q <= 1'b0;
`endif
        end else begin
            mbus_ack_o <= '0;
            case (state)
                ST_IDLE: begin
                    mask <= '0;
                    if (pick_valid) begin
                        gid        <= pick_id;
                        grant_id_o <= pick_id;
                        busy_o     <= 1'b1;
                        if ((sel_cmd == MBUS_BR_WR) || (sel_cmd == MBUS_BR_RD)) begin
                            state       <= ST_SNOOP;
                            cbus_addr_o <= sel_addr;
                            for (int k = 0; k < CPU_NUM; k++) begin
                                cbus_q[k] <= (2'(k) == pick_id) ? CBUS_NOP : snoop_cmd;
                            end
`ifdef MESI_ARB_SNOOP_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            state      <= ST_MEM;
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= (sel_cmd == MBUS_WR);
                            mem_addr_o <= sel_addr;
                        end
                    end
                end

                ST_SNOOP: begin
                    ack_seen <= seen_next;
                    for (int k = 0; k < CPU_NUM; k++) begin
                        if (seen_next[k]) begin
                            cbus_q[k] <= CBUS_NOP;
                        end
                    end
                    if (seen_next == others) begin
                        state <= ST_DONE;
                    end
`ifdef MESI_ARB_SNOOP_TIMEOUT_EN
                    else if (tmo_cnt == 32'(SNOOP_TIMEOUT - 1)) begin
                        snoop_err_q <= 1'b1;
                        for (int k = 0; k < CPU_NUM; k++) begin
                            cbus_q[k] <= CBUS_NOP;
                        end
                        state <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end

                ST_MEM: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // The mask gives the requester one IDLE cycle to withdraw its command.
                    mbus_ack_o <= CPU_NUM'(1) << gid;
                    mask       <= CPU_NUM'(1) << gid;
                    rr_ptr     <= gid + 2'd1;
                    ack_seen   <= '0;
                    busy_o     <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mesi_mbus_arb.md
Name: mesi_mbus_arb

Overview:
- Main-bus arbiter and transaction sequencer shared by the 4 CPU-side MESI cache controllers.
- Selects one pending main-bus request round-robin and classifies it by command.
- Broadcast requests: drives coherence-bus snoop commands to the other three caches, collects their acks, then acks the requester.
- Plain read/write requests: forwards to the memory port, waits for the memory ack, then acks the requester.

Parameters:
- ADDR_WIDTH, 32, address width.
- MBUS_CMD_WIDTH, 3, main-bus command width.
- CBUS_CMD_WIDTH, 3, coherence-bus command width.
- CPU_NUM, 4, number of requesters (fixed at 4 in this revision).
- SNOOP_TIMEOUT, 64, snoop timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mbus_cmd_i  in  CPU_NUM*MBUS_CMD_WIDTH  per-CPU main-bus command; CPU k at slice k
- mbus_addr_i  in  CPU_NUM*ADDR_WIDTH  per-CPU main-bus address
- mbus_ack_o  out  CPU_NUM  per-CPU transaction-complete pulse
- cbus_cmd_o  out  CPU_NUM*CBUS_CMD_WIDTH  per-CPU snoop command
- cbus_addr_o  out  ADDR_WIDTH  snoop address, common to all CPUs
- cbus_ack_i  in  CPU_NUM  per-CPU snoop acknowledge
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable (1 = write)
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_ack_i  in  1  memory completion
- grant_id_o  out  2  id of the current grantee
- busy_o  out  1  high in any state other than IDLE
- snoop_err_o  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Command encodings:
  - MBUS: NOP=0, WR=1, RD=2, BR_WR=3, BR_RD=4.
  - CBUS: NOP=0, WR_SNOOP=1, RD_SNOOP=2.
  - Any other MBUS value is treated as NOP.
- Reset (rst low, asynchronous): every output is 0, state=IDLE, rr_ptr=0, mask=0, ack_seen=0.
- All outputs are registered.
- FSM states: IDLE, SNOOP, MEM, DONE.
- IDLE:
  - req[k] = (cmd_k != NOP) && !mask[k].
  - Grant the first req at or after rr_ptr, scanning upward modulo 4.
  - Latch id, cmd and addr; drive grant_id_o.
  - BR_WR/BR_RD: go to SNOOP. For every k != id, set cbus_cmd_o[k] = WR_SNOOP / RD_SNOOP respectively and cbus_addr_o = addr.
  - WR/RD: go to MEM. Set mem_req_o=1, mem_we_o=(cmd==WR), mem_addr_o=addr.
  - No request: stay in IDLE.
  - mask clears to 0 on every IDLE cycle.
- SNOOP:
  - Each cycle, ack_seen |= cbus_ack_i & others.
  - cbus_cmd_o[k] goes to NOP the edge after ack k is seen.
  - Acks from the requester itself, or from CPUs already acked, are ignored.
  - When (ack_seen | cbus_ack_i) covers all others: go to DONE, all cbus_cmd_o = NOP.
  - Acks from several CPUs in the same cycle are all accepted.
- MEM:
  - Hold mem_req_o, mem_we_o and mem_addr_o stable until mem_ack_i.
  - On mem_ack_i: deassert mem_req_o and go to DONE.
  - mem_ack_i seen in any other state is ignored.
- DONE:
  - mbus_ack_o[id]=1 for exactly one cycle.
  - rr_ptr = id+1 (mod 4).
  - mask = one-hot(id), so the requester has one cycle to drop its command.
  - Clear ack_seen; go to IDLE.
- Minimum latency, counted from the IDLE grant edge:
  - Snoop with all acks in the first cycle: mbus_ack_o high after the 2nd edge.
  - Memory access with same-cycle mem_ack_i: mbus_ack_o high after the 2nd edge.
- A requester changing mbus_cmd_i mid-transaction has no effect; the latched values are used.
- rst asserted mid-transaction aborts immediately to the reset values; no ack is issued.

Optional Feature:
- MESI_ARB_SNOOP_TIMEOUT_EN defined:
  - A counter clears on SNOOP entry and increments each SNOOP cycle.
  - When it reaches SNOOP_TIMEOUT-1 with acks still missing: set snoop_err_o (sticky until reset), force all cbus_cmd_o to NOP, go to DONE.
  - The requester is still acked.
- Undefined: no counter, snoop_err_o tied 0, SNOOP waits indefinitely.

Decomposition:
- Package mesi_arb_pkg:
  - mbus_cmd_t and cbus_cmd_t enums with the encodings above.
  - arb_state_t enum.
  - CPU_NUM constant.
- Sub-module mesi_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0]. Outputs: valid, id[1:0].

Test Plan:
- Reset, then cpu0 BR_RD addr 0x100; acks from cpu1,2,3 in the first cycle.
  - cbus_cmd_o[1..3]=RD_SNOOP, cbus_cmd_o[0]=NOP, cbus_addr_o=0x100.
  - mbus_ack_o=4'b0001 for 1 cycle, 2 edges after grant.
- cpu2 WR addr 0x40; mem_ack_i 3 cycles after mem_req_o rises.
  - mem_we_o=1 and mem_addr_o=0x40 held until mem_ack_i.
  - mbus_ack_o[2] pulses the following cycle.
- All 4 CPUs issue RD continuously, each dropping its command 1 cycle after its ack and re-raising it.
  - Grant order 0,1,2,3,0; no CPU granted twice in a row.
- cpu1 BR_WR; cpu3 acks in cycle 1, cpu0 in cycle 3, cpu2 in cycle 5.
  - cbus_cmd_o[3] drops first, then [0], then [2].
  - mbus_ack_o[1] follows the cpu2 ack by 1 cycle.
- With MESI_ARB_SNOOP_TIMEOUT_EN and SNOOP_TIMEOUT=8: cpu0 BR_WR with no acks.
  - After 8 SNOOP cycles: snoop_err_o=1, mbus_ack_o[0] pulses, snoop_err_o stays 1 afterwards.
- rst low during MEM.
  - mem_req_o=0 immediately, no mbus_ack_o.
  - After release, the FSM is in IDLE and re-grants cpu0 first.
